// File: rtl/snax_tcdm_req_buffer.sv
// snax_tcdm_req_buffer
// Per-port decoupling stage between an accelerator TCDM port and the cluster
// TCDM interconnect: request FIFO, outstanding-read credit counter, sticky
// protocol error flag and registered read-response path.
// Optional feature macro: SNAX_TCDM_BUF_PERF_EN (enables the stall counter
// behind stall_cnt_o; when undefined the output is tied to zero).
module snax_tcdm_req_buffer #(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned ReqDepth       = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 in_q_valid_i,
    output logic                                 in_q_ready_o,
    input  logic [AddrWidth-1:0]                 in_q_addr_i,
    input  logic                                 in_q_write_i,
    input  logic [DataWidth-1:0]                 in_q_data_i,
    input  logic [DataWidth/8-1:0]               in_q_strb_i,
    output logic                                 in_p_valid_o,
    output logic [DataWidth-1:0]                 in_p_data_o,
    output logic                                 out_q_valid_o,
    input  logic                                 out_q_ready_i,
    output logic [AddrWidth-1:0]                 out_q_addr_o,
    output logic                                 out_q_write_o,
    output logic [DataWidth-1:0]                 out_q_data_o,
    output logic [DataWidth/8-1:0]               out_q_strb_o,
    input  logic                                 out_p_valid_i,
    input  logic [DataWidth-1:0]                 out_p_data_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 err_o,
    output logic [31:0]                          stall_cnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(ReqDepth);
    localparam int unsigned CntWidth  = $clog2(ReqDepth + 1);
    localparam int unsigned OutWidth  = $clog2(MaxOutstanding + 1);
    localparam int unsigned EntWidth  = AddrWidth + 1 + DataWidth + StrbWidth;

    // Entry layout (MSB..LSB): addr, write, data, strb
    logic [EntWidth-1:0]  r_mem [ReqDepth];
    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [CntWidth-1:0]  r_count;
    logic [OutWidth-1:0]  r_outstanding;
    logic                 r_err;
    logic                 r_p_valid;
    logic [DataWidth-1:0] r_p_data;

    logic [EntWidth-1:0]  w_in_entry;
    logic [EntWidth-1:0]  w_head;
    logic                 w_head_write;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_credit;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_issue;

    assign w_in_entry   = {in_q_addr_i, in_q_write_i, in_q_data_i, in_q_strb_i};
    assign w_head       = r_mem[r_rptr];
    assign w_head_write = w_head[DataWidth+StrbWidth];

    assign w_full   = (r_count == CntWidth'(ReqDepth));
    assign w_empty  = (r_count == '0);
    assign w_credit = (r_outstanding < OutWidth'(MaxOutstanding));

    // Ready is a function of the occupancy only; it is also forced low while
    // reset is held so every output reads zero during reset.
    assign w_in_ready  = rst_ni && !w_full;
    // A gated read at the head blocks everything behind it (no reordering).
    assign w_out_valid = !w_empty && (w_head_write || w_credit);

    assign w_push     = in_q_valid_i && w_in_ready;
    assign w_pop      = w_out_valid && out_q_ready_i;
    assign w_rd_issue = w_pop && !w_head_write;

    assign in_q_ready_o  = w_in_ready;
    assign out_q_valid_o = w_out_valid;
    assign out_q_addr_o  = w_head[EntWidth-1 -: AddrWidth];
    assign out_q_write_o = w_head_write;
    assign out_q_data_o  = w_head[StrbWidth +: DataWidth];
    assign out_q_strb_o  = w_head[StrbWidth-1:0];
    assign in_p_valid_o  = r_p_valid;
    assign in_p_data_o   = r_p_data;
    assign outstanding_o = r_outstanding;
    assign err_o         = r_err;

    // Request storage; cleared on reset so the head fields read zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(ReqDepth); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_in_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outstanding-read credits and sticky error on an unexpected response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else if (w_rd_issue && !out_p_valid_i) begin
            r_outstanding <= r_outstanding + OutWidth'(1);
        end else if (!w_rd_issue && out_p_valid_i) begin
            if (r_outstanding == '0) begin
                r_err <= 1'b1;
            end else begin
                r_outstanding <= r_outstanding - OutWidth'(1);
            end
        end
    end

    // Registered response path; data holds between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p_valid <= 1'b0;
            r_p_data  <= '0;
        end else begin
            r_p_valid <= out_p_valid_i;
            if (out_p_valid_i) begin
                r_p_data <= out_p_data_i;
            end
        end
    end

`ifdef SNAX_TCDM_BUF_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where a request is offered but the interconnect stalls it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_q_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_snax_tcdm_req_buffer.sv
// Testbench for snax_tcdm_req_buffer: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based model.
module tb_snax_tcdm_req_buffer;

    localparam int MAXO  = 4;
    localparam int DEPTH = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        in_q_valid_i;
    logic        in_q_ready_o;
    logic [47:0] in_q_addr_i;
    logic        in_q_write_i;
    logic [63:0] in_q_data_i;
    logic [7:0]  in_q_strb_i;
    logic        in_p_valid_o;
    logic [63:0] in_p_data_o;
    logic        out_q_valid_o;
    logic        out_q_ready_i;
    logic [47:0] out_q_addr_o;
    logic        out_q_write_o;
    logic [63:0] out_q_data_o;
    logic [7:0]  out_q_strb_o;
    logic        out_p_valid_i;
    logic [63:0] out_p_data_i;
    logic [2:0]  outstanding_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    snax_tcdm_req_buffer #(
        .AddrWidth(48), .DataWidth(64), .ReqDepth(DEPTH), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_q_valid_i(in_q_valid_i), .in_q_ready_o(in_q_ready_o),
        .in_q_addr_i(in_q_addr_i), .in_q_write_i(in_q_write_i),
        .in_q_data_i(in_q_data_i), .in_q_strb_i(in_q_strb_i),
        .in_p_valid_o(in_p_valid_o), .in_p_data_o(in_p_data_o),
        .out_q_valid_o(out_q_valid_o), .out_q_ready_i(out_q_ready_i),
        .out_q_addr_o(out_q_addr_o), .out_q_write_o(out_q_write_o),
        .out_q_data_o(out_q_data_o), .out_q_strb_o(out_q_strb_o),
        .out_p_valid_i(out_p_valid_i), .out_p_data_i(out_p_data_i),
        .outstanding_o(outstanding_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [47:0] addr;
        logic        wr;
        logic [63:0] data;
        logic [7:0]  strb;
    } req_t;

    // Reference model state
    req_t        mq[$];
    int          m_out;
    logic        m_err;
    logic [31:0] m_stall;
    logic        m_pv;
    logic [63:0] m_pd;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out   = 0;
        m_err   = 1'b0;
        m_stall = 32'd0;
        m_pv    = 1'b0;
        m_pd    = 64'd0;
    endtask

    function automatic logic m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic logic m_valid();
        return (mq.size() > 0) && (mq[0].wr || (m_out < MAXO));
    endfunction

    task automatic model_check();
        logic v;
        v = m_valid();
        chk("in_q_ready", 64'(in_q_ready_o), 64'(m_ready()));
        chk("out_q_valid", 64'(out_q_valid_o), 64'(v));
        if (v) begin
            chk("out_q_addr", 64'(out_q_addr_o), 64'(mq[0].addr));
            chk("out_q_write", 64'(out_q_write_o), 64'(mq[0].wr));
            chk("out_q_data", out_q_data_o, mq[0].data);
            chk("out_q_strb", 64'(out_q_strb_o), 64'(mq[0].strb));
        end
        chk("in_p_valid", 64'(in_p_valid_o), 64'(m_pv));
        chk("in_p_data", in_p_data_o, m_pd);
        chk("outstanding", 64'(outstanding_o), 64'(m_out));
        chk("err", 64'(err_o), 64'(m_err));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic push, pop, rd, v;
        req_t r;
        v    = m_valid();
        push = in_q_valid_i && m_ready();
        pop  = v && out_q_ready_i;
        rd   = pop && !mq[0].wr;
`ifdef SNAX_TCDM_BUF_PERF_EN
        if (v && !out_q_ready_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
        if (pop) void'(mq.pop_front());
        if (push) begin
            r = '{addr: in_q_addr_i, wr: in_q_write_i, data: in_q_data_i, strb: in_q_strb_i};
            mq.push_back(r);
        end
        if (rd && !out_p_valid_i) m_out++;
        else if (!rd && out_p_valid_i) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
        end
        m_pv = out_p_valid_i;
        if (out_p_valid_i) m_pd = out_p_data_i;
    endtask

    // One clock: drive at negedge, compare, step model, return #1 after posedge.
    task automatic cycle(input logic v, input logic w, input logic [47:0] a,
                         input logic [63:0] d, input logic [7:0] s,
                         input logic ordy, input logic pv, input logic [63:0] pd);
        @(negedge clk_i);
        in_q_valid_i  = v;
        in_q_write_i  = w;
        in_q_addr_i   = a;
        in_q_data_i   = d;
        in_q_strb_i   = s;
        out_q_ready_i = ordy;
        out_p_valid_i = pv;
        out_p_data_i  = pd;
        #1;
        model_check();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic pv, input logic [63:0] pd);
        cycle(1'b0, 1'b0, 48'd0, 64'd0, 8'd0, ordy, pv, pd);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 0 && m_out == 0) break;
            idle(1'b1, (m_out > 0), {$urandom(), $urandom()});
        end
        chk("drain_done", 64'(mq.size() + m_out), 64'd0);
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_in_q_ready"}, 64'(in_q_ready_o), 64'd0);
        chk({p, "_out_q_valid"}, 64'(out_q_valid_o), 64'd0);
        chk({p, "_out_q_addr"}, 64'(out_q_addr_o), 64'd0);
        chk({p, "_out_q_write"}, 64'(out_q_write_o), 64'd0);
        chk({p, "_out_q_data"}, out_q_data_o, 64'd0);
        chk({p, "_out_q_strb"}, 64'(out_q_strb_o), 64'd0);
        chk({p, "_in_p_valid"}, 64'(in_p_valid_o), 64'd0);
        chk({p, "_in_p_data"}, in_p_data_o, 64'd0);
        chk({p, "_outstanding"}, 64'(outstanding_o), 64'd0);
        chk({p, "_err"}, 64'(err_o), 64'd0);
        chk({p, "_stall"}, 64'(stall_cnt_o), 64'd0);
    endtask

    initial begin
        logic [31:0] stall_before;
        logic [31:0] exp_stall;
        checks = 0;
        errors = 0;
        rst_ni = 1'b0;
        in_q_valid_i = 1'b0; in_q_write_i = 1'b0; in_q_addr_i = '0;
        in_q_data_i = '0; in_q_strb_i = '0; out_q_ready_i = 1'b0;
        out_p_valid_i = 1'b0; out_p_data_i = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("post_reset_ready", 64'(in_q_ready_o), 64'd1);
        $display("step: reset released");

        // Single read
        cycle(1'b1, 1'b0, 48'h100, 64'd0, 8'hFF, 1'b1, 1'b0, 64'd0);
        chk("single_valid", 64'(out_q_valid_o), 64'd1);
        chk("single_addr", 64'(out_q_addr_o), 64'h100);
        idle(1'b1, 1'b0, 64'd0);
        chk("single_outstanding", 64'(outstanding_o), 64'd1);
        idle(1'b1, 1'b1, 64'hDEAD_BEEF);
        chk("single_resp_valid", 64'(in_p_valid_o), 64'd1);
        chk("single_resp_data", in_p_data_o, 64'hDEAD_BEEF);
        chk("single_outstanding0", 64'(outstanding_o), 64'd0);
        idle(1'b1, 1'b0, 64'd0);
        chk("single_resp_hold", in_p_data_o, 64'hDEAD_BEEF);
        $display("step: single read done");

        // Credit limit
        for (int k = 0; k < 6; k++)
            cycle(1'b1, 1'b0, 48'h200 + 48'(k * 8), 64'd0, 8'hFF, 1'b1, 1'b0, 64'd0);
        chk("credit_out4", 64'(outstanding_o), 64'd4);
        chk("credit_blocked", 64'(out_q_valid_o), 64'd0);
        idle(1'b1, 1'b0, 64'd0);
        chk("credit_still_blocked", 64'(out_q_valid_o), 64'd0);
        idle(1'b1, 1'b1, 64'h1111);
        chk("credit_out3", 64'(outstanding_o), 64'd3);
        chk("credit_5th_valid", 64'(out_q_valid_o), 64'd1);
        chk("credit_5th_addr", 64'(out_q_addr_o), 64'h220);
        idle(1'b1, 1'b0, 64'd0);
        chk("credit_out4_again", 64'(outstanding_o), 64'd4);
        drain();
        $display("step: credit limit done");

        // FIFO full with stalls
        stall_before = stall_cnt_o;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 48'h300 + 48'(k * 8), {$urandom(), $urandom()},
                  8'($urandom()), 1'b0, 1'b0, 64'd0);
            if (k == 3) chk("full_ready_low", 64'(in_q_ready_o), 64'd0);
        end
`ifdef SNAX_TCDM_BUF_PERF_EN
        exp_stall = stall_before + 32'd4;
`else
        exp_stall = 32'd0;
`endif
        chk("full_stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b0, 64'd0);
        chk("full_emptied_valid", 64'(out_q_valid_o), 64'd0);
        $display("step: fifo full done");

        // Simultaneous handshake and response at outstanding 2
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 1'b0, 48'h400 + 48'(k * 8), 64'd0, 8'hFF, 1'b1, 1'b0, 64'd0);
        idle(1'b1, 1'b1, 64'h2222);
        chk("simul_out2", 64'(outstanding_o), 64'd2);
        drain();
        // Simultaneous push and pop at count 3
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 1'b1, 48'h500 + 48'(k * 8), 64'(k), 8'h0F, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 48'h518, 64'd3, 8'h0F, 1'b1, 1'b0, 64'd0);
        chk("pushpop_ready", 64'(in_q_ready_o), 64'd1);
        cycle(1'b1, 1'b1, 48'h520, 64'd4, 8'h0F, 1'b0, 1'b0, 64'd0);
        chk("pushpop_count3", 64'(in_q_ready_o), 64'd0);
        drain();
        $display("step: simultaneous events done");

        // Protocol error
        idle(1'b1, 1'b1, 64'h5555);
        chk("proto_err", 64'(err_o), 64'd1);
        chk("proto_out0", 64'(outstanding_o), 64'd0);
        chk("proto_fwd", in_p_data_o, 64'h5555);
        idle(1'b1, 1'b0, 64'd0);
        chk("proto_sticky", 64'(err_o), 64'd1);
        $display("step: protocol error done");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  48'({$urandom(), $urandom()}), {$urandom(), $urandom()}, 8'($urandom()),
                  ($urandom_range(0, 9) < 7), (m_out > 0) && ($urandom_range(0, 1) == 1),
                  {$urandom(), $urandom()});
        end
        drain();
        $display("step: random traffic done");

        // Reset mid-operation: 3 queued, 2 outstanding
        cycle(1'b1, 1'b0, 48'h600, 64'd0, 8'hFF, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 48'h608, 64'd0, 8'hFF, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 48'h610, 64'd1, 8'hFF, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 48'h618, 64'd2, 8'hFF, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 48'h620, 64'd3, 8'hFF, 1'b0, 1'b0, 64'd0);
        chk("midrst_out2", 64'(outstanding_o), 64'd2);
        @(negedge clk_i);
        in_q_valid_i = 1'b0; out_q_ready_i = 1'b0; out_p_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("midrst_ready", 64'(in_q_ready_o), 64'd1);
        chk("midrst_outstanding", 64'(outstanding_o), 64'd0);
        for (int n = 0; n < 20; n++) begin
            cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  48'({$urandom(), $urandom()}), {$urandom(), $urandom()}, 8'($urandom()),
                  1'b1, (m_out > 0), {$urandom(), $urandom()});
        end
        drain();
        $display("step: mid-operation reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
